// File: rtl/riscv_multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// master = controller (consumes instruction fields, drives selects/enables), slave = datapath.
interface riscv_multicycle_controller_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               Zero;

    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ImmSrc;
    logic               RegWrite;
    logic [2:0]         ALUControl;
    logic               IllegalInstr;
    logic [STATE_W-1:0] StateOut;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, IllegalInstr, StateOut
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, IllegalInstr, StateOut
    );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath (lw/sw/R/I/beq/jal).
// Latency: outputs follow the current state; no backpressure, one step per clock.
module riscv_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    riscv_multicycle_controller_if.master bus
);
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               op_legal;

    logic       pc_write_raw;
    logic       adr_src;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write_raw;
    logic       illegal_raw;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    assign op_legal = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                      (bus.op == OP_I)  || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = S_MEMWB;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_DECODE: begin
                // Branch target PC_old + imm is staged in ALUOut here.
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                illegal_raw = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = bus.Zero;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    // Only R-type (op[5]=1) may subtract; addi ignores Instr[30].
                    3'b000:  alu_control = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    assign bus.PCWrite      = pc_write_raw  & ~reset;
    assign bus.IRWrite      = ir_write_raw  & ~reset;
    assign bus.RegWrite     = reg_write_raw & ~reset;
    assign bus.MemWrite     = mem_write_raw & ~reset;
    assign bus.IllegalInstr = illegal_raw   & ~reset;
    assign bus.AdrSrc       = adr_src;
    assign bus.ResultSrc    = result_src;
    assign bus.ALUSrcA      = alu_src_a;
    assign bus.ALUSrcB      = alu_src_b;
    assign bus.ImmSrc       = imm_src;
    assign bus.ALUControl   = alu_control;
    assign bus.StateOut     = state;
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: per-instruction state walks and control words
// checked against a table-driven model of the instruction sequencing.
module tb_riscv_multicycle_controller;
    localparam int STATE_W = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    riscv_multicycle_controller_if #(.STATE_W(STATE_W)) bus ();

    riscv_multicycle_controller #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,IllegalInstr}
    logic [16:0] obs;
    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl,
                  bus.IllegalInstr};

    function automatic bit is_legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == BEQ || op == JAL;
    endfunction

    // Cycles per instruction class.
    function automatic int seq_len(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW, RT, IT, JAL: return 4;
            BEQ:     return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at step i of an instruction, from the instruction's step list.
    function automatic logic [3:0] seq_at(input logic [6:0] op, input int i);
        logic [3:0] s [5];
        case (op)
            LW:      s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            SW:      s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
            RT:      s = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
            IT:      s = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
            BEQ:     s = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
            JAL:     s = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
            default: s = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        endcase
        return s[i];
    endfunction

    function automatic logic [16:0] exp_ctl(input logic [3:0] s, input logic [6:0] op,
                                            input logic [2:0] f3, input logic f7,
                                            input logic zero, input logic rst);
        logic pcw, adr, memw, irw, regw, ill;
        logic [1:0] res, sa, sb, imm, aluop;
        logic [2:0] alu;
        {pcw, adr, memw, irw, regw, ill} = '0;
        {res, sa, sb, aluop} = '0;
        case (s)
            4'd0:  begin irw = 1; sb = 2; res = 2; pcw = 1; end
            4'd1:  begin sa = 1; sb = 1; ill = !is_legal(op); end
            4'd2:  begin sa = 2; sb = 1; end
            4'd3:  adr = 1;
            4'd4:  begin res = 1; regw = 1; end
            4'd5:  begin adr = 1; memw = 1; end
            4'd6:  begin sa = 2; aluop = 2; end
            4'd7:  begin sa = 2; sb = 1; aluop = 2; end
            4'd8:  regw = 1;
            4'd9:  begin sa = 2; aluop = 1; pcw = zero; end
            4'd10: begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        if (aluop == 0) alu = 3'b000;
        else if (aluop == 1) alu = 3'b001;
        else if (f3 == 3'b000) alu = (op == RT && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) alu = 3'b101;
        else if (f3 == 3'b110) alu = 3'b011;
        else if (f3 == 3'b111) alu = 3'b010;
        else alu = 3'b000;
        imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
        if (rst) {pcw, irw, regw, memw, ill} = '0;
        return {pcw, adr, memw, irw, res, sa, sb, imm, regw, alu, ill};
    endfunction

    task automatic test_reset();
        logic [16:0] e;
        reset = 1'b1;
        bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = exp_ctl(4'd0, bus.op, bus.funct3, bus.funct7b5, bus.Zero, 1'b1);
            total++;
            if (bus.StateOut !== 4'd0) begin
                bad++; $display("FAIL reset_state cyc%0d got=%0d want=0", c, bus.StateOut);
            end
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL reset_ctl cyc%0d got=%h want=%h", c, obs, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // Walks one whole instruction from FETCH, checking state and control word each cycle.
    task automatic test_instruction(input string name, input logic [6:0] op,
                                    input logic [2:0] f3, input logic f7, input int zmode);
        logic [16:0] e;
        logic [3:0]  s;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        for (int i = 0; i < seq_len(op); i++) begin
            bus.Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            s = seq_at(op, i);
            e = exp_ctl(s, op, f3, f7, bus.Zero, 1'b0);
            total++;
            if (bus.StateOut !== s) begin
                bad++; $display("FAIL %s_state step%0d got=%0d want=%0d", name, i, bus.StateOut, s);
            end
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL %s_ctl step%0d got=%h want=%h", name, i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reset = 1'b1;
            @(negedge clk);
            total++;
            if (bus.StateOut !== seq_at(LW, i)) begin
                bad++; $display("FAIL rstmid_state step%0d got=%0d want=%0d", i, bus.StateOut, seq_at(LW, i));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        e = exp_ctl(4'd0, LW, 3'b000, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.StateOut !== 4'd0) begin
            bad++; $display("FAIL rstmid_fetch got=%0d want=0", bus.StateOut);
        end
        total++;
        if (bus.RegWrite !== 1'b0 || obs !== e) begin
            bad++; $display("FAIL rstmid_ctl got=%h want=%h", obs, e);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [7];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [16:0] e;
        logic [3:0]  s;
        ops = '{LW, SW, RT, IT, BEQ, JAL, BAD};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(6)];
            if (op == BAD) op = 7'($urandom);
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
            for (int i = 0; i < seq_len(op); i++) begin
                bus.Zero = 1'($urandom);
                @(negedge clk);
                s = seq_at(op, i);
                e = exp_ctl(s, op, f3, f7, bus.Zero, 1'b0);
                total++;
                if (bus.StateOut !== s || obs !== e) begin
                    bad++;
                    $display("FAIL rand op=%b step%0d state got=%0d want=%0d ctl got=%h want=%h",
                             op, i, bus.StateOut, s, obs, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_instruction("lw",        LW,  3'b010, 1'b0, 2);
        test_instruction("sw",        SW,  3'b010, 1'b0, 2);
        test_instruction("r_sub",     RT,  3'b000, 1'b1, 2);
        test_instruction("r_add",     RT,  3'b000, 1'b0, 2);
        test_instruction("r_and",     RT,  3'b111, 1'b0, 2);
        test_instruction("r_slt",     RT,  3'b010, 1'b0, 2);
        test_instruction("r_or",      RT,  3'b110, 1'b1, 2);
        test_instruction("r_other",   RT,  3'b001, 1'b1, 2);
        test_instruction("addi_f7",   IT,  3'b000, 1'b1, 2);
        test_instruction("beq_taken", BEQ, 3'b000, 1'b0, 1);
        test_instruction("beq_not",   BEQ, 3'b000, 1'b0, 0);
        test_instruction("jal",       JAL, 3'b000, 1'b0, 2);
        test_instruction("illegal",   BAD, 3'b000, 1'b0, 2);
        test_instruction("after_ill", IT,  3'b111, 1'b0, 2);
        test_reset_mid();
        test_instruction("post_rst",  LW,  3'b010, 1'b0, 2);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
